// File: rtl/module_captura_pkg.sv
// Shared types, key codes and key classification for the operand-entry controller.
package pkg_captura;

   // Entry FSM states; the encoding is exported on the estado port.
   typedef enum logic [1:0] {
      CAP_1 = 2'd0,
      CAP_2 = 2'd1,
      LISTO = 2'd2
   } t_estado;

   localparam logic [3:0] TEC_ENTER = 4'hA;
   localparam logic [3:0] TEC_CLEAR = 4'hB;

   // True for decimal digit keys 0-9.
   function automatic logic es_digito(input logic [3:0] tecla);
      return (tecla <= 4'd9);
   endfunction

endpackage

// File: rtl/module_captura_acumulador.sv
// Decimal operand accumulator: value*10 + digit with range and digit-count limits.
module module_acumulador #(
   parameter int unsigned ANCHO   = 8,
   parameter int unsigned MAX_DIG = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               load_digit,
   input  logic                               clear,
   input  logic [3:0]                         digit,
   output logic [ANCHO-1:0]                   value,
   output logic [$clog2(MAX_DIG+1)-1:0]       count,
   output logic                               acepta
);

   localparam int unsigned CNT_W = $clog2(MAX_DIG + 1);
   localparam int unsigned EXT_W = ANCHO + 4;
   localparam logic [EXT_W-1:0] MAX_VAL = EXT_W'((64'd1 << ANCHO) - 64'd1);

   logic [ANCHO-1:0] value_q, value_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [EXT_W-1:0] nuevo;

   // Candidate value and accept flag for the next digit on the current contents.
   always_comb begin
      nuevo  = EXT_W'(value_q) * EXT_W'(10) + EXT_W'(digit);
      acepta = (count_q < CNT_W'(MAX_DIG)) && (nuevo <= MAX_VAL);
   end

   // Next contents: clear has priority; clear together with load starts a fresh operand.
   always_comb begin
      value_d = value_q;
      count_d = count_q;
      if (clear && load_digit) begin
         value_d = ANCHO'(digit);
         count_d = CNT_W'(1);
      end else if (clear) begin
         value_d = '0;
         count_d = '0;
      end else if (load_digit && acepta) begin
         value_d = nuevo[ANCHO-1:0];
         count_d = count_q + CNT_W'(1);
      end
   end

   // Operand and digit-count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         count_q <= count_d;
      end
   end

   assign value = value_q;
   assign count = count_q;

endmodule

// File: rtl/module_captura.sv
// Operand-entry controller: keypad strobes to two operands, ready flags and a start pulse.
module module_captura
   import pkg_captura::*;
#(
   parameter int unsigned ANCHO   = 8,
   parameter int unsigned MAX_DIG = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       tecla,
   input  logic             tecla_valida,
   output logic [ANCHO-1:0] num_1,
   output logic [ANCHO-1:0] num_2,
   output logic             listo_1,
   output logic             listo,
   output logic             inicio,
   output logic [1:0]       estado
);

   localparam int unsigned CNT_W = $clog2(MAX_DIG + 1);

   t_estado          estado_q, estado_d;
   logic             listo_1_q, listo_1_d;
   logic             listo_q, listo_d;
   logic             inicio_q, inicio_d;

   logic             ld_1, clr_1, ld_2, clr_2;
   logic             acepta_1, acepta_2;
   logic [CNT_W-1:0] cnt_1, cnt_2;
   logic             k_dig, k_ent, k_clr;

   // Key classification; unqualified strobes and codes C-F decode to nothing.
   always_comb begin
      k_dig = tecla_valida && es_digito(tecla);
      k_ent = tecla_valida && (tecla == TEC_ENTER);
      k_clr = tecla_valida && (tecla == TEC_CLEAR);
   end

   // Operand 1 keeps its digit count while operand 2 is typed, so a return
   // from CAP_2 resumes editing where it left off.
   module_acumulador #(.ANCHO(ANCHO), .MAX_DIG(MAX_DIG)) u_acc_1 (
      .clk       (clk),
      .rst       (rst),
      .load_digit(ld_1),
      .clear     (clr_1),
      .digit     (tecla),
      .value     (num_1),
      .count     (cnt_1),
      .acepta    (acepta_1)
   );

   module_acumulador #(.ANCHO(ANCHO), .MAX_DIG(MAX_DIG)) u_acc_2 (
      .clk       (clk),
      .rst       (rst),
      .load_digit(ld_2),
      .clear     (clr_2),
      .digit     (tecla),
      .value     (num_2),
      .count     (cnt_2),
      .acepta    (acepta_2)
   );

   // Next-state, flag and accumulator-control decode.
   always_comb begin
      estado_d  = estado_q;
      listo_1_d = listo_1_q;
      listo_d   = listo_q;
      inicio_d  = 1'b0;
      ld_1      = 1'b0;
      clr_1     = 1'b0;
      ld_2      = 1'b0;
      clr_2     = 1'b0;
      case (estado_q)
         CAP_1: begin
            if (k_dig) begin
               ld_1 = acepta_1;
            end else if (k_ent && (cnt_1 != '0)) begin
               listo_1_d = 1'b1;
               estado_d  = CAP_2;
            end else if (k_clr) begin
               clr_1 = 1'b1;
            end
         end
         CAP_2: begin
            if (k_dig) begin
               ld_2 = acepta_2;
            end else if (k_ent && (cnt_2 != '0)) begin
               listo_d  = 1'b1;
               inicio_d = 1'b1;
               estado_d = LISTO;
            end else if (k_clr) begin
               if (cnt_2 != '0) begin
                  clr_2 = 1'b1;
               end else begin
                  listo_1_d = 1'b0;
                  estado_d  = CAP_1;
               end
            end
         end
         LISTO: begin
            if (k_dig || k_clr) begin
               clr_1     = 1'b1;
               clr_2     = 1'b1;
               ld_1      = k_dig;
               listo_1_d = 1'b0;
               listo_d   = 1'b0;
               estado_d  = CAP_1;
            end
         end
         default: begin
            clr_1     = 1'b1;
            clr_2     = 1'b1;
            listo_1_d = 1'b0;
            listo_d   = 1'b0;
            estado_d  = CAP_1;
         end
      endcase
   end

   // State and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q  <= CAP_1;
         listo_1_q <= 1'b0;
         listo_q   <= 1'b0;
         inicio_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         listo_1_q <= listo_1_d;
         listo_q   <= listo_d;
         inicio_q  <= inicio_d;
      end
   end

   assign listo_1 = listo_1_q;
   assign listo   = listo_q;
   assign inicio  = inicio_q;
   assign estado  = 2'(estado_q);

endmodule

// File: tb/tb_module_captura.sv
// Directed bench for module_captura: keypad sequences with hand-computed expectations.
module tb_module_captura;

   logic       clk;
   logic       rst;
   logic [3:0] tecla;
   logic       tecla_valida;
   logic [7:0] num_1, num_2;
   logic       listo_1, listo, inicio;
   logic [1:0] estado;

   int n_total = 0;
   int n_pass  = 0;

   module_captura #(.ANCHO(8), .MAX_DIG(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .tecla       (tecla),
      .tecla_valida(tecla_valida),
      .num_1       (num_1),
      .num_2       (num_2),
      .listo_1     (listo_1),
      .listo       (listo),
      .inicio      (inicio),
      .estado      (estado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // One-cycle strobe; returns at the next falling edge, after the capturing edge.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      tecla        = k;
      tecla_valida = 1'b1;
      @(negedge clk);
      tecla_valida = 1'b0;
   endtask

   task automatic chk_all(input string tag, input int n1, input int n2,
                          input int l1, input int l, input int ini, input int st);
      chk({tag, ".num_1"},   int'(num_1),   n1);
      chk({tag, ".num_2"},   int'(num_2),   n2);
      chk({tag, ".listo_1"}, int'(listo_1), l1);
      chk({tag, ".listo"},   int'(listo),   l);
      chk({tag, ".inicio"},  int'(inicio),  ini);
      chk({tag, ".estado"},  int'(estado),  st);
   endtask

   initial begin
      rst          = 1'b1;
      tecla        = 4'h0;
      tecla_valida = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_all("reset", 0, 0, 0, 0, 0, 0);

      // Basic entry 15 x 10
      press(4'd1);
      press(4'd5);
      chk("entry.n1", int'(num_1), 15);
      press(4'hA);
      chk_all("enter1", 15, 0, 1, 0, 0, 1);
      press(4'd1);
      press(4'd0);
      chk("entry.n2", int'(num_2), 10);
      press(4'hA);
      chk_all("enter2", 15, 10, 1, 1, 1, 2);
      @(negedge clk);
      chk("inicio_once", int'(inicio), 0);

      // Repeated Enter in LISTO: no extra start pulse
      for (int i = 0; i < 3; i++) begin
         press(4'hA);
         chk_all("listo_enter", 15, 10, 1, 1, 0, 2);
      end

      // Digit in LISTO restarts with that digit in operand 1
      press(4'd7);
      chk_all("restart", 7, 0, 0, 0, 0, 0);

      // Range and count limits
      press(4'hB);
      chk("clr_cap1", int'(num_1), 0);
      press(4'd2); press(4'd5); press(4'd5);
      chk("max255", int'(num_1), 255);
      press(4'd7);
      chk("count_lim", int'(num_1), 255);
      press(4'hB);
      press(4'd2); press(4'd5); press(4'd6);
      chk("no_wrap", int'(num_1), 25);

      // Enter with no digits is ignored
      press(4'hB);
      press(4'hA);
      chk_all("empty_enter", 0, 0, 0, 0, 0, 0);

      // Codes C-F ignored
      press(4'd3);
      for (int k = 12; k < 16; k++) press(4'(k));
      chk_all("codes_cf", 3, 0, 0, 0, 0, 0);

      // Key changes without strobe ignored
      @(negedge clk);
      tecla = 4'd9;
      @(negedge clk);
      tecla = 4'hA;
      @(negedge clk);
      chk_all("no_strobe", 3, 0, 0, 0, 0, 0);

      // Clear paths in CAP_2
      press(4'hB);
      press(4'd1); press(4'd5); press(4'hA);
      press(4'd3);
      chk("cap2.n2", int'(num_2), 3);
      press(4'hB);
      chk_all("cap2_clr", 15, 0, 1, 0, 0, 1);
      press(4'hB);
      chk_all("back_cap1", 15, 0, 0, 0, 0, 0);
      press(4'd2);
      chk("append", int'(num_1), 152);
      press(4'd3);
      chk("append_lim", int'(num_1), 152);

      // Reset mid-operation wins over a strobe
      press(4'hA);
      press(4'd4);
      chk_all("pre_rst", 152, 4, 1, 0, 0, 1);
      @(negedge clk);
      rst          = 1'b1;
      tecla        = 4'd5;
      tecla_valida = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      tecla_valida = 1'b0;
      chk_all("mid_rst", 0, 0, 0, 0, 0, 0);

      // Clear from LISTO returns to reset values
      press(4'd9); press(4'hA); press(4'd2); press(4'hA);
      chk_all("ready2", 9, 2, 1, 1, 1, 2);
      press(4'hB);
      chk_all("listo_clr", 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/module_captura.md
Name: module_captura

Overview:
- Operand-entry controller. Feeds the display priority selector and the multiplier.
- Converts one-cycle keypad strobes (decimal digits, Enter, Clear) into two unsigned 8-bit operands.
- Produces the ready flags listo_1 and listo, and a start pulse for the multiplier.
- Operand values are visible live while they are typed.

Parameters:
- ANCHO, 8: operand width in bits. Maximum operand value is 2**ANCHO-1.
- MAX_DIG, 3: maximum number of decimal digits per operand.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tecla  in  4  key code: 0-9 digit, 4'hA Enter, 4'hB Clear, 4'hC-4'hF ignored.
- tecla_valida  in  1  one-cycle strobe qualifying tecla.
- num_1  out  ANCHO  operand 1, live accumulator.
- num_2  out  ANCHO  operand 2, live accumulator.
- listo_1  out  1  operand 1 confirmed (level).
- listo  out  1  operand 2 confirmed, operation ready (level).
- inicio  out  1  one-cycle start pulse to the multiplier.
- estado  out  2  current FSM state, for debug/LED.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (rst, sampled on the rising edge of clk).
- All outputs are registered. A key sampled at edge N is reflected at the outputs after edge N (latency 1).
- Reset values:
  - num_1 = 0, num_2 = 0
  - listo_1 = 0, listo = 0, inicio = 0
  - estado = CAP_1
  - digit counter = 0
- rst has priority over tecla_valida in the same cycle. Reset mid-entry discards all partial data.
- tecla is ignored whenever tecla_valida = 0. Codes 4'hC-4'hF are ignored in every state.
- Digit rule, applied to the active operand acc:
  - nuevo = acc*10 + d, computed at ANCHO+4 bits.
  - Accept only if count < MAX_DIG and nuevo <= 2**ANCHO-1; then acc <= nuevo and count <= count+1.
  - Otherwise the key is dropped: no change, no wrap, no saturation.
  - A leading zero counts as a digit (key 0 gives acc = 0, count = 1).
- State CAP_1 (estado = 0), active operand num_1:
  - Digit: apply the digit rule.
  - Enter with count > 0: listo_1 <= 1, count <= 0, go to CAP_2.
  - Enter with count = 0: ignored.
  - Clear: num_1 <= 0, count <= 0.
- State CAP_2 (estado = 1), active operand num_2; num_1 and listo_1 are held:
  - Digit: apply the digit rule to num_2.
  - Enter with count > 0: listo <= 1, inicio <= 1 for exactly one cycle, go to LISTO.
  - Enter with count = 0: ignored.
  - Clear with count > 0: num_2 <= 0, count <= 0, stay in CAP_2.
  - Clear with count = 0: return to CAP_1. Set listo_1 <= 0; keep num_1 and restore its digit count for further editing.
- State LISTO (estado = 2): operands, listo_1 and listo are held.
  - Enter: ignored, no second inicio.
  - Clear: full clear (reset values) and go to CAP_1.
  - Digit: full clear, then load that digit into num_1 (count = 1), go to CAP_1, in the same cycle.
- estado = 3 is unreachable. If entered, the next edge returns to CAP_1 with reset values.
- inicio is never high for two consecutive cycles.
- listo implies listo_1 at all times.

Decomposition:
- Package pkg_captura:
  - Enum t_estado {CAP_1, CAP_2, LISTO}.
  - Constants TEC_ENTER = 4'hA, TEC_CLEAR = 4'hB.
  - Function es_digito(tecla).
- Sub-module module_acumulador:
  - Instantiated twice, once per operand.
  - Inputs: load_digit, clear, digit.
  - Outputs: value, count, acepta (combinational accept flag for the FSM).
  - Holds the ×10 + d arithmetic and the range and count checks.
- Top level: FSM, listo_1/listo/inicio registers, digit-count restore path.

Test Plan:
- Reset and entry: rst for 2 cycles, keys 1,5,Enter,1,0,Enter.
  - Expect num_1 = 15 and listo_1 = 1 one cycle after the first Enter.
  - Expect num_2 = 10, listo = 1 and a single-cycle inicio one cycle after the second Enter.
- Range limit: keys 2,5,5 give num_1 = 255; a further 7 is dropped (count limit).
  - Separately, 2,5,6 gives num_1 = 25, with 6 dropped; check no wrap.
- Edge cases:
  - Enter with no digits: state stays CAP_1, no flags raised.
  - Codes 4'hC-4'hF: no output change.
  - tecla changing while tecla_valida = 0: ignored.
- Clear paths:
  - In CAP_2, 3,Clear gives num_2 = 0, stay in CAP_2.
  - A second Clear returns to CAP_1 with num_1 kept, listo_1 = 0.
  - Appending 2 to num_1 = 15 then gives 152.
- Restart from LISTO: with 15×10 ready, key 7 gives num_1 = 7, num_2 = 0, listo_1 = listo = 0, CAP_1.
  - Enter held repeatedly in LISTO produces no extra inicio.
- Reset mid-operation: rst asserted in CAP_2 with num_2 = 4 and tecla_valida = 1 in the same cycle.
  - All outputs return to reset values next edge; the key is ignored.
